wb_port_arbiter: RTL

- Shares the register bank's single write port among NUM_REQ functional-unit writeback requesters, using round-robin arbitration.
- Also forwards dispatch's register-invalidate stream to the bank's invalidate port, aligned to the same one-cycle latency as writes.
- Detects a same-cycle write/invalidate to the same register and flags it.
- Sits between the execution units / dispatch stage and regbank.

---
 rtl/wb_port_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: round-robin sharing of the register bank's single
// write port among NUM_REQ functional units, plus a one-cycle aligned
// forward of dispatch's invalidate stream and same-register collision flag.
module wb_port_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 5,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
  input  logic                            port_hold,
  input  logic [ADDR_W-1:0]               disp_inval_addr,
  output logic [ADDR_W-1:0]               write_address,
  output logic [DATA_W-1:0]               write_data,
  output logic [ADDR_W-1:0]               invalidate_register,
  output logic                            wb_collision,
  output logic [IDX_W-1:0]                grant_idx
);

  // Registered state
  logic [IDX_W-1:0]  rr_ptr_q,        rr_ptr_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic [DATA_W-1:0] write_data_q,    write_data_d;
  logic [ADDR_W-1:0] inval_q,         inval_d;
  logic              collision_q,     collision_d;
  logic [IDX_W-1:0]  grant_idx_q,     grant_idx_d;

  // Combinational arbitration results
  logic [NUM_REQ-1:0] zero_ack;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant_oh;
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_sel;
  logic [IDX_W-1:0]   probe;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [DATA_W-1:0]  gnt_data;
  logic               collision_hit;

  // Classify requests, pick the first candidate at or above rr_ptr (wrapping)
  // and compute next-state values for every register.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment, so
    // no path leaves a value unassigned and no latch is inferred.
    zero_ack      = '0;
    cand          = '0;
    grant_oh      = '0;
    grant_vld     = 1'b0;
    grant_sel     = '0;
    probe         = '0;
    gnt_addr      = '0;
    gnt_data      = '0;
    collision_hit = 1'b0;

    // Zero-address writebacks need no port, so they are acknowledged directly.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !reset) begin
        if (req_addr[i] == '0) zero_ack[i] = 1'b1;
        else                   cand[i]     = 1'b1;
      end
    end

    if (!port_hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        probe = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!grant_vld && cand[probe]) begin
          grant_vld = 1'b1;
          grant_sel = probe;
        end
      end
    end

    if (grant_vld) begin
      grant_oh[grant_sel] = 1'b1;
      gnt_addr            = req_addr[grant_sel];
      gnt_data            = req_data[grant_sel];
      collision_hit       = (disp_inval_addr != '0) && (gnt_addr == disp_inval_addr);
    end

    // Next-state defaults hold or clear, then a grant overrides.
    rr_ptr_d        = rr_ptr_q;
    write_address_d = '0;
    write_data_d    = write_data_q;
    inval_d         = disp_inval_addr;
    collision_d     = collision_q | collision_hit;
    grant_idx_d     = grant_idx_q;

    if (grant_vld) begin
      rr_ptr_d     = (grant_sel == IDX_W'(NUM_REQ - 1)) ? '0 : grant_sel + 1'b1;
      grant_idx_d  = grant_sel;
      write_data_d = gnt_data;
      // A same-cycle invalidate of the target register wins: the write is dropped.
      if (!collision_hit) write_address_d = gnt_addr;
    end
  end

  // Acknowledge zero-address requests and the single granted candidate.
  assign req_ready = zero_ack | grant_oh;

  // State update with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // the pre-edge value of every other flop, regardless of statement order.
    if (reset) begin
      rr_ptr_q        <= '0;
      write_address_q <= '0;
      write_data_q    <= '0;
      inval_q         <= '0;
      collision_q     <= 1'b0;
      grant_idx_q     <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      inval_q         <= inval_d;
      collision_q     <= collision_d;
      grant_idx_q     <= grant_idx_d;
    end
  end

  // NOTE: outputs are forced low while reset is high so the bank sees a quiet
  // port in the very first reset cycle, before the flops have been cleared.
  assign write_address       = reset ? '0   : write_address_q;
  assign write_data          = reset ? '0   : write_data_q;
  assign invalidate_register = reset ? '0   : inval_q;
  assign wb_collision        = reset ? 1'b0 : collision_q;
  assign grant_idx           = reset ? '0   : grant_idx_q;

endmodule
